pmod_i2c_scheduler: RTL and testbench

Sequences all I2C traffic for one `eurorack-pmod` in front of the I2C transaction engine. It drives CODEC power-down release and a one-shot startup sequence of CODEC config, LED driver config and EEPROM read. It then runs a periodic schedule of jack polls, LED updates and, optionally, touch reads, paced by the sample `strobe`. Only one transaction is ever in flight; the engine executes whatever job ID it is handed.

---
 rtl/pmod_i2c_pkg.sv | 54 +++++
 rtl/pmod_i2c_scheduler_strobe_divider.sv | 35 +++
 rtl/pmod_i2c_scheduler.sv | 269 ++++++++++++++++++++++++++
 tb/tb_pmod_i2c_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmod_i2c_pkg.sv
// Shared types and constants for the eurorack-pmod I2C scheduler.
//   job_id_e : job selector handed to the I2C transaction engine
//   state_e  : scheduler FSM states
//   widths   : job id, error counter, timers, strobe dividers, retry count
//   helpers  : first_set() priority pick, slot_job() run-slot to job id
package pmod_i2c_pkg;

    localparam int JOB_W   = 3;
    localparam int ERR_W   = 8;
    localparam int TIMER_W = 24;
    localparam int DIV_W   = 16;
    localparam int RETRY_W = 8;
    localparam int NUM_RUN = 3;

    typedef enum logic [JOB_W-1:0] {
        JOB_CODEC_CFG = 3'd0,
        JOB_LED_CFG   = 3'd1,
        JOB_EEPROM    = 3'd2,
        JOB_JACK      = 3'd3,
        JOB_LED_UPD   = 3'd4,
        JOB_TOUCH     = 3'd5
    } job_id_e;

    typedef enum logic [2:0] {
        PWR_LOW,
        PWR_WAIT,
        INIT_ISSUE,
        INIT_WAIT,
        IDLE,
        ISSUE,
        WAIT
    } state_e;

    // Run-phase slots, listed in base priority order.
    localparam int SLOT_JACK  = 0;
    localparam int SLOT_TOUCH = 1;
    localparam int SLOT_LED   = 2;

    // Lowest set index wins; returns the last slot when nothing is set.
    function automatic logic [1:0] first_set(input logic [NUM_RUN-1:0] v);
        if (v[SLOT_JACK])       return 2'd0;
        else if (v[SLOT_TOUCH]) return 2'd1;
        else                    return 2'd2;
    endfunction

    function automatic logic [JOB_W-1:0] slot_job(input logic [1:0] s);
        case (s)
            2'd0:    return JOB_JACK;
            2'd1:    return JOB_TOUCH;
            default: return JOB_LED_UPD;
        endcase
    endfunction

endpackage

// File: rtl/pmod_i2c_scheduler_strobe_divider.sv
// strobe_divider: counts sample strobes and emits a one-cycle tick on every
// DIV-th strobe, then wraps.  Held at its reload value while en is low.
//   clk_256fs, rst_n : clock, async active-low reset
//   en               : count enable
//   strobe           : one-cycle sample-rate tick
//   tick             : one-cycle pulse, coincident with the DIV-th strobe
module strobe_divider
    import pmod_i2c_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic clk_256fs,
    input  logic rst_n,
    input  logic en,
    input  logic strobe,
    output logic tick
);

    localparam logic [DIV_W-1:0] RELOAD = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] cnt_q;

    assign tick = en && strobe && (cnt_q == '0);

    always_ff @(posedge clk_256fs or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RELOAD;
        end else if (!en) begin
            cnt_q <= RELOAD;
        end else if (strobe) begin
            cnt_q <= (cnt_q == '0) ? RELOAD : cnt_q - DIV_W'(1);
        end
    end

endmodule

// File: rtl/pmod_i2c_scheduler.sv
// pmod_i2c_scheduler: sequences all I2C traffic for one eurorack-pmod.
// Releases CODEC power-down, runs the startup jobs (CODEC cfg, LED cfg,
// EEPROM read) with retries, then schedules jack polls, LED updates and
// optional touch reads from strobe-driven dividers, one job in flight.
//   clk_256fs, rst_n      : clock, async active-low reset
//   strobe                : sample-rate tick feeding the run-phase dividers
//   pdn                   : CODEC power-down (0 = powered down)
//   job_valid/ready/id    : job offer handshake to the I2C engine
//   job_done/job_err      : end-of-job pulse and NACK qualifier
//   job_abort             : one-cycle pulse when a job times out
//   cfg_done, eeprom_done : startup finished / EEPROM read succeeded
//   err_count             : saturating error + timeout count
//
// state      | meaning
// -----------+------------------------------------------------------
// PWR_LOW    | pdn held low for PDN_LOW_CYCLES
// PWR_WAIT   | pdn high, waiting STARTUP_DELAY before the first job
// INIT_ISSUE | offering a startup job
// INIT_WAIT  | startup job in flight; retry on error/timeout
// IDLE       | run phase, picking the next pending job
// ISSUE      | offering a run-phase job
// WAIT       | run-phase job in flight
module pmod_i2c_scheduler
    import pmod_i2c_pkg::*;
#(
    parameter int PDN_LOW_CYCLES = 1024,
    parameter int STARTUP_DELAY  = 4096,
    parameter int JACK_DIV       = 16,
    parameter int LED_DIV        = 4,
    parameter int TOUCH_EN       = 0,
    parameter int TOUCH_DIV      = 8,
    parameter int TIMEOUT        = 65535,
    parameter int MAX_RETRY      = 3
) (
    input  logic             clk_256fs,
    input  logic             rst_n,
    input  logic             strobe,
    output logic             pdn,
    output logic             job_valid,
    input  logic             job_ready,
    output logic [JOB_W-1:0] job_id,
    input  logic             job_done,
    input  logic             job_err,
    output logic             job_abort,
    output logic             cfg_done,
    output logic             eeprom_done,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [TIMER_W-1:0] PDN_RELOAD = TIMER_W'(PDN_LOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SU_RELOAD  = TIMER_W'(STARTUP_DELAY - 1);
    localparam logic [TIMER_W-1:0] TO_RELOAD  = TIMER_W'(TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM  = RETRY_W'(MAX_RETRY);

    state_e                      state_q, state_d;
    logic [TIMER_W-1:0]          timer_q, timer_d;
    logic [RETRY_W-1:0]          retry_q, retry_d;
    logic [NUM_RUN-1:0][1:0]     pass_q, pass_d;
    logic [NUM_RUN-1:0]          pend_q, tick_v, clr, starved;
    logic [1:0]                  sel_slot;
    logic                        timer_zero;
    logic                        tick_jack, tick_touch, tick_led;
    logic                        pdn_d, job_valid_d, job_abort_d;
    logic                        cfg_done_d, eeprom_done_d;
    logic [JOB_W-1:0]            job_id_d;
    logic [ERR_W-1:0]            err_count_d;
    logic                        err_inc, init_fail, init_ok;

    strobe_divider #(.DIV(JACK_DIV)) u_jack_div (
        .clk_256fs (clk_256fs),
        .rst_n     (rst_n),
        .en        (cfg_done),
        .strobe    (strobe),
        .tick      (tick_jack)
    );

    strobe_divider #(.DIV(TOUCH_DIV)) u_touch_div (
        .clk_256fs (clk_256fs),
        .rst_n     (rst_n),
        .en        (cfg_done && (TOUCH_EN != 0)),
        .strobe    (strobe),
        .tick      (tick_touch)
    );

    strobe_divider #(.DIV(LED_DIV)) u_led_div (
        .clk_256fs (clk_256fs),
        .rst_n     (rst_n),
        .en        (cfg_done),
        .strobe    (strobe),
        .tick      (tick_led)
    );

    assign tick_v     = {tick_led, tick_touch, tick_jack};
    assign timer_zero = (timer_q == '0);

    // A job passed over twice in a row overrides base priority.
    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_RUN; i++) begin
            starved[i] = pend_q[i] && (pass_q[i] == 2'd2);
        end
        sel_slot = (|starved) ? first_set(starved) : first_set(pend_q);
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        retry_d       = retry_q;
        pass_d        = pass_q;
        pdn_d         = pdn;
        job_valid_d   = job_valid;
        job_id_d      = job_id;
        job_abort_d   = 1'b0;
        cfg_done_d    = cfg_done;
        eeprom_done_d = eeprom_done;
        err_count_d   = err_count;
        clr           = '0;
        err_inc       = 1'b0;
        init_fail     = 1'b0;
        init_ok       = 1'b0;

        case (state_q)
            PWR_LOW: begin
                if (timer_zero) begin
                    pdn_d   = 1'b1;
                    timer_d = SU_RELOAD;
                    state_d = PWR_WAIT;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            PWR_WAIT: begin
                if (timer_zero) begin
                    job_valid_d = 1'b1;
                    job_id_d    = JOB_CODEC_CFG;
                    retry_d     = '0;
                    state_d     = INIT_ISSUE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            INIT_ISSUE: begin
                if (job_ready) begin
                    job_valid_d = 1'b0;
                    timer_d     = TO_RELOAD;
                    state_d     = INIT_WAIT;
                end
            end

            INIT_WAIT: begin
                if (job_done) begin
                    if (job_err) begin
                        err_inc   = 1'b1;
                        init_fail = 1'b1;
                    end else begin
                        init_ok = 1'b1;
                        if (job_id == JOB_EEPROM) eeprom_done_d = 1'b1;
                    end
                end else if (timer_zero) begin
                    job_abort_d = 1'b1;
                    err_inc     = 1'b1;
                    init_fail   = 1'b1;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end

                // After the last retry fails the sequence moves on regardless.
                if (init_fail && (retry_q < RETRY_LIM)) begin
                    retry_d     = retry_q + RETRY_W'(1);
                    job_valid_d = 1'b1;
                    state_d     = INIT_ISSUE;
                end else if (init_fail || init_ok) begin
                    retry_d = '0;
                    if (job_id == JOB_EEPROM) begin
                        cfg_done_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        job_id_d    = job_id + JOB_W'(1);
                        job_valid_d = 1'b1;
                        state_d     = INIT_ISSUE;
                    end
                end
            end

            IDLE: begin
                if (|pend_q) begin
                    job_id_d    = slot_job(sel_slot);
                    job_valid_d = 1'b1;
                    state_d     = ISSUE;
                    for (int i = 0; i < NUM_RUN; i++) begin
                        if (pend_q[i] && (2'(i) != sel_slot)) begin
                            pass_d[i] = (pass_q[i] == 2'd2) ? 2'd2 : pass_q[i] + 2'd1;
                        end else begin
                            pass_d[i] = 2'd0;
                        end
                    end
                end
            end

            ISSUE: begin
                if (job_ready) begin
                    job_valid_d     = 1'b0;
                    timer_d         = TO_RELOAD;
                    state_d         = WAIT;
                    clr[SLOT_JACK]  = (job_id == JOB_JACK);
                    clr[SLOT_TOUCH] = (job_id == JOB_TOUCH);
                    clr[SLOT_LED]   = (job_id == JOB_LED_UPD);
                end
            end

            WAIT: begin
                if (job_done) begin
                    err_inc = job_err;
                    state_d = IDLE;
                end else if (timer_zero) begin
                    job_abort_d = 1'b1;
                    err_inc     = 1'b1;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            default: state_d = PWR_LOW;
        endcase

        if (err_inc && (err_count != '1)) err_count_d = err_count + ERR_W'(1);
    end

    always_ff @(posedge clk_256fs or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PWR_LOW;
            timer_q     <= PDN_RELOAD;
            retry_q     <= '0;
            pass_q      <= '0;
            pdn         <= 1'b0;
            job_valid   <= 1'b0;
            job_id      <= '0;
            job_abort   <= 1'b0;
            cfg_done    <= 1'b0;
            eeprom_done <= 1'b0;
            err_count   <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            pass_q      <= pass_d;
            pdn         <= pdn_d;
            job_valid   <= job_valid_d;
            job_id      <= job_id_d;
            job_abort   <= job_abort_d;
            cfg_done    <= cfg_done_d;
            eeprom_done <= eeprom_done_d;
            err_count   <= err_count_d;
        end
    end

    // A tick landing on the accept cycle keeps the bit set.
    always_ff @(posedge clk_256fs or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~clr) | tick_v;
        end
    end

endmodule

// File: tb/tb_pmod_i2c_scheduler.sv
// Directed bench for pmod_i2c_scheduler: power sequencing timing, startup
// order with retries and timeout, run-phase priority/starvation, error
// saturation and asynchronous reset.
module tb_pmod_i2c_scheduler;

    logic       clk_256fs = 1'b0;
    logic       rst_n     = 1'b0;
    logic       strobe    = 1'b0;
    logic       job_ready = 1'b0;
    logic       job_done  = 1'b0;
    logic       job_err   = 1'b0;
    logic       pdn, job_valid, job_abort, cfg_done, eeprom_done;
    logic [2:0] job_id;
    logic [7:0] err_count;

    int tests  = 0;
    int failed = 0;
    int xfers  = 0;
    int aborts = 0;
    int vcount = 0;

    always #5 clk_256fs = ~clk_256fs;

    pmod_i2c_scheduler #(
        .PDN_LOW_CYCLES (1024),
        .STARTUP_DELAY  (4096),
        .JACK_DIV       (1),
        .LED_DIV        (2),
        .TOUCH_EN       (1),
        .TOUCH_DIV      (8),
        .TIMEOUT        (100),
        .MAX_RETRY      (3)
    ) dut (
        .clk_256fs   (clk_256fs),
        .rst_n       (rst_n),
        .strobe      (strobe),
        .pdn         (pdn),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_id      (job_id),
        .job_done    (job_done),
        .job_err     (job_err),
        .job_abort   (job_abort),
        .cfg_done    (cfg_done),
        .eeprom_done (eeprom_done),
        .err_count   (err_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        if (job_valid === 1'b1 && job_ready === 1'b1) xfers++;
        @(posedge clk_256fs);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (job_valid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(job_valid), 32'd1);
    endtask

    task automatic accept();
        job_ready = 1'b1;
        tick();
        job_ready = 1'b0;
    endtask

    task automatic finish_job(input logic err);
        job_done = 1'b1;
        job_err  = err;
        tick();
        job_done = 1'b0;
        job_err  = 1'b0;
    endtask

    task automatic pulse_strobe();
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_pdn",         32'(pdn),         32'd0);
        check("rst_job_valid",   32'(job_valid),   32'd0);
        check("rst_job_id",      32'(job_id),      32'd0);
        check("rst_job_abort",   32'(job_abort),   32'd0);
        check("rst_cfg_done",    32'(cfg_done),    32'd0);
        check("rst_eeprom_done", 32'(eeprom_done), 32'd0);
        check("rst_err_count",   32'(err_count),   32'd0);

        // pdn rises on the 1024th edge after release
        rst_n = 1'b1;
        repeat (1023) tick();
        check("pdn_low_1023", 32'(pdn), 32'd0);
        tick();
        check("pdn_high_1024", 32'(pdn), 32'd1);

        // first job offered 4096 edges later
        repeat (4095) tick();
        check("valid_low_5119", 32'(job_valid), 32'd0);
        tick();
        check("valid_high_5120", 32'(job_valid), 32'd1);
        check("first_id", 32'(job_id), 32'd0);

        // engine stalls 10 cycles: offer stays stable
        vcount = 0;
        repeat (10) begin
            tick();
            if (job_valid === 1'b1 && job_id === 3'd0) vcount++;
        end
        check("stall_stable", 32'(vcount), 32'd10);

        // accept with job_done in the same cycle: the done must be ignored
        xfers     = 0;
        job_ready = 1'b1;
        job_done  = 1'b1;
        tick();
        job_done  = 1'b0;
        check("valid_drop", 32'(job_valid), 32'd0);
        repeat (3) tick();
        job_ready = 1'b0;
        check("done_in_xfer_ignored", 32'(job_valid), 32'd0);
        check("one_transfer", 32'(xfers), 32'd1);
        finish_job(1'b0);

        // LED_CFG NACKed four times: 1 issue + 3 retries, then EEPROM
        for (int r = 0; r < 4; r++) begin
            wait_valid("led_cfg");
            check("led_cfg_id", 32'(job_id), 32'd1);
            accept();
            finish_job(1'b1);
        end
        wait_valid("eeprom");
        check("eeprom_id", 32'(job_id), 32'd2);
        check("err_after_led", 32'(err_count), 32'd4);
        check("cfg_not_done", 32'(cfg_done), 32'd0);

        // EEPROM never answers: abort exactly 100 cycles after acceptance
        accept();
        aborts = 0;
        repeat (99) begin
            tick();
            if (job_abort !== 1'b0) aborts++;
        end
        check("no_early_abort", 32'(aborts), 32'd0);
        tick();
        check("abort_pulse", 32'(job_abort), 32'd1);
        check("err_after_timeout", 32'(err_count), 32'd5);
        check("eeprom_retry_valid", 32'(job_valid), 32'd1);
        check("eeprom_retry_id", 32'(job_id), 32'd2);
        tick();
        check("abort_one_cycle", 32'(job_abort), 32'd0);
        check("eeprom_not_done", 32'(eeprom_done), 32'd0);
        accept();
        finish_job(1'b0);
        check("cfg_done", 32'(cfg_done), 32'd1);
        check("eeprom_done", 32'(eeprom_done), 32'd1);

        // RUN: nothing requested yet
        repeat (3) tick();
        check("run_idle", 32'(job_valid), 32'd0);

        // strobe 1 starts a jack poll; strobes 2..8 pile up touch and LED
        pulse_strobe();
        repeat (7) begin
            pulse_strobe();
            tick();
        end
        check("order_1_valid", 32'(job_valid), 32'd1);
        check("order_1_id", 32'(job_id), 32'd3);
        accept();
        finish_job(1'b0);
        check("done_to_valid_gap", 32'(job_valid), 32'd0);
        tick();
        check("done_to_valid_2cyc", 32'(job_valid), 32'd1);
        check("order_2_id", 32'(job_id), 32'd5);
        accept();
        finish_job(1'b0);
        wait_valid("order_3");
        check("order_3_id", 32'(job_id), 32'd4);
        accept();
        finish_job(1'b0);
        vcount = 0;
        repeat (5) begin
            tick();
            if (job_valid === 1'b1) vcount++;
        end
        check("coalesced", 32'(vcount), 32'd0);

        // continuous jack requests: LED still gets through within 3 jobs
        pulse_strobe();
        wait_valid("cont_1");
        check("cont_1_id", 32'(job_id), 32'd3);
        accept();
        pulse_strobe();
        finish_job(1'b0);
        wait_valid("cont_2");
        check("cont_2_id", 32'(job_id), 32'd3);
        job_ready = 1'b1;
        strobe    = 1'b1;
        tick();
        job_ready = 1'b0;
        strobe    = 1'b0;
        finish_job(1'b0);
        wait_valid("cont_3");
        check("cont_3_set_wins", 32'(job_id), 32'd3);
        accept();
        pulse_strobe();
        finish_job(1'b0);
        wait_valid("cont_4");
        check("cont_4_led", 32'(job_id), 32'd4);
        accept();
        finish_job(1'b0);
        wait_valid("cont_5");
        check("cont_5_id", 32'(job_id), 32'd3);
        accept();
        finish_job(1'b0);
        check("err_before_sat", 32'(err_count), 32'd5);

        // 300 NACKed run jobs: counter saturates at 255
        for (int i = 0; i < 300; i++) begin
            pulse_strobe();
            wait_valid("sat");
            accept();
            finish_job(1'b1);
            if (i == 0)   check("err_first", 32'(err_count), 32'd6);
            if (i == 244) check("err_250", 32'(err_count), 32'd250);
        end
        check("err_saturated", 32'(err_count), 32'd255);

        // reset asserted mid-WAIT clears outputs without a clock edge
        pulse_strobe();
        wait_valid("pre_reset");
        accept();
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_pdn",         32'(pdn),         32'd0);
        check("midrst_job_valid",   32'(job_valid),   32'd0);
        check("midrst_job_id",      32'(job_id),      32'd0);
        check("midrst_job_abort",   32'(job_abort),   32'd0);
        check("midrst_cfg_done",    32'(cfg_done),    32'd0);
        check("midrst_eeprom_done", 32'(eeprom_done), 32'd0);
        check("midrst_err_count",   32'(err_count),   32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("post_rst_pdn", 32'(pdn), 32'd0);
        check("post_rst_valid", 32'(job_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
